// File: rtl/sccb_arbiter.sv
// -----------------------------------------------------------------------------
// sccb_arbiter
//   Shares one SCCBCtrl transaction engine between two register requesters
//   (port 0: boot-time camera setup sequencer, port 1: runtime host port).
//   Generates the SCCB bit clock and the engine data pulse, grants the engine
//   round-robin, retries ACK failures and aborts hung transfers by watchdog.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   reqN_i/rwN_i/regN_i/wdataN_i request and its fields, held until ackN_o
//   ackN_o/errN_o                one-clk completion pulse and error flag
//   tmo_o                        with ack: the failure was a watchdog timeout
//   rdata_o                      read data, valid from ack until the next ack
//   gnt_o                        one-hot engine owner, 00 when idle
//   sccb_clk_o, data_pulse_o     SCCB bit clock and engine sampling strobe
//   eng_data_o/eng_rw_o/eng_start_o   engine command
//   eng_done_i/eng_ack_error_i/eng_data_i  engine status and read data
// -----------------------------------------------------------------------------
module sccb_arbiter #(
    parameter int IN_FREQ        = 24_000_000,
    parameter int SCCB_FREQ      = 100_000,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_PULSES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        rw0_i,
    input  logic        rw1_i,
    input  logic [7:0]  reg0_i,
    input  logic [7:0]  reg1_i,
    input  logic [7:0]  wdata0_i,
    input  logic [7:0]  wdata1_i,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic        err0_o,
    output logic        err1_o,
    output logic        tmo_o,
    output logic [7:0]  rdata_o,
    output logic [1:0]  gnt_o,
    output logic        sccb_clk_o,
    output logic        data_pulse_o,
    output logic [15:0] eng_data_o,
    output logic        eng_rw_o,
    output logic        eng_start_o,
    input  logic        eng_done_i,
    input  logic        eng_ack_error_i,
    input  logic [7:0]  eng_data_i
);

    localparam int SCCB_PERIOD = IN_FREQ / SCCB_FREQ / 2;
    localparam int CNT_W       = $clog2(SCCB_PERIOD) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCCB_PERIOD);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(SCCB_PERIOD / 2);
    localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);
    localparam logic [7:0]       PULSE_MAX = 8'(TIMEOUT_PULSES);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_BUSY = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    logic [CNT_W-1:0] cnt_r;
    logic             sccb_clk_r;
    logic             data_pulse_s;

    logic [2:0]  state_r;
    logic [1:0]  gnt_r;
    logic        port_r;
    logic        last_r;
    logic [2:0]  retry_r;
    logic [7:0]  pcnt_r;
    logic        seen_busy_r;
    logic        start_r;
    logic        cap_rw_r;
    logic [7:0]  cap_reg_r;
    logic [7:0]  cap_wdata_r;

    logic        ack0_r;
    logic        ack1_r;
    logic        err0_r;
    logic        err1_r;
    logic        tmo_r;
    logic [7:0]  rdata_r;

    logic        sel_s;
    logic [7:0]  pcnt_nxt_s;
    logic        done_evt_s;
    logic        retry_evt_s;
    logic        tmo_evt_s;
    logic        finish_s;
    logic        fin_err_s;

    // SCCB bit clock: half period is SCCB_PERIOD+1 clk_i cycles
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r      <= {CNT_W{1'b0}};
            sccb_clk_r <= 1'b0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r      <= {CNT_W{1'b0}};
            sccb_clk_r <= ~sccb_clk_r;
        end else begin
            cnt_r      <= cnt_r + CNT_W'(1);
        end
    end

    // Strobe in the middle of the low half of the bit clock
    assign data_pulse_s = (cnt_r == CNT_HALF) && !sccb_clk_r;

    // Round-robin pick: on contention the port not served last wins
    always_comb begin
        if (req0_i && req1_i) begin
            sel_s = ~last_r;
        end else if (req1_i) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Per-pulse BUSY evaluation: completion, retry decision and watchdog
    always_comb begin
        pcnt_nxt_s = pcnt_r + 8'd1;
        if ((state_r == ST_BUSY) && data_pulse_s) begin
            // done only counts once the engine has been seen busy, so the
            // idle-high done from before the start is not taken as completion
            done_evt_s  = seen_busy_r && eng_done_i;
            retry_evt_s = done_evt_s && eng_ack_error_i && (retry_r < RETRY_MAX);
            tmo_evt_s   = !done_evt_s && (pcnt_nxt_s == PULSE_MAX);
        end else begin
            done_evt_s  = 1'b0;
            retry_evt_s = 1'b0;
            tmo_evt_s   = 1'b0;
        end
        finish_s  = (done_evt_s && !retry_evt_s) || tmo_evt_s;
        fin_err_s = tmo_evt_s || eng_ack_error_i;
    end

    // Arbitration / transaction sequencing FSM
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_IDLE;
            gnt_r       <= 2'b00;
            port_r      <= 1'b0;
            last_r      <= 1'b1;
            retry_r     <= 3'd0;
            pcnt_r      <= 8'd0;
            seen_busy_r <= 1'b0;
            start_r     <= 1'b0;
            cap_rw_r    <= 1'b0;
            cap_reg_r   <= 8'd0;
            cap_wdata_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req0_i || req1_i) begin
                        port_r      <= sel_s;
                        gnt_r       <= sel_s ? 2'b10 : 2'b01;
                        cap_rw_r    <= sel_s ? rw1_i : rw0_i;
                        cap_reg_r   <= sel_s ? reg1_i : reg0_i;
                        cap_wdata_r <= sel_s ? wdata1_i : wdata0_i;
                        retry_r     <= 3'd0;
                        state_r     <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (data_pulse_s) begin
                        start_r     <= 1'b1;
                        seen_busy_r <= 1'b0;
                        pcnt_r      <= 8'd0;
                        state_r     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (data_pulse_s) begin
                        if (!eng_done_i) begin
                            seen_busy_r <= 1'b1;
                        end
                        pcnt_r <= pcnt_nxt_s;
                        if (retry_evt_s) begin
                            start_r <= 1'b0;
                            retry_r <= retry_r + 3'd1;
                            state_r <= ST_GAP;
                        end else if (finish_s) begin
                            start_r <= 1'b0;
                            state_r <= ST_RESP;
                        end
                    end
                end
                ST_GAP: begin
                    // one full pulse with start low lets the engine re-arm
                    if (data_pulse_s) begin
                        state_r <= ST_ARM;
                    end
                end
                ST_RESP: begin
                    last_r  <= port_r;
                    gnt_r   <= 2'b00;
                    state_r <= ST_IDLE;
                end
                default: begin
                    start_r <= 1'b0;
                    gnt_r   <= 2'b00;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Response registers: ack/err/tmo are high exactly during the RESP cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            err0_r  <= 1'b0;
            err1_r  <= 1'b0;
            tmo_r   <= 1'b0;
            rdata_r <= 8'd0;
        end else begin
            ack0_r <= finish_s && !port_r;
            ack1_r <= finish_s && port_r;
            err0_r <= finish_s && !port_r && fin_err_s;
            err1_r <= finish_s && port_r && fin_err_s;
            tmo_r  <= finish_s && tmo_evt_s;
            if (finish_s && cap_rw_r && !fin_err_s) begin
                rdata_r <= eng_data_i;
            end
        end
    end

    assign ack0_o       = ack0_r;
    assign ack1_o       = ack1_r;
    assign err0_o       = err0_r;
    assign err1_o       = err1_r;
    assign tmo_o        = tmo_r;
    assign rdata_o      = rdata_r;
    assign gnt_o        = gnt_r;
    assign sccb_clk_o   = sccb_clk_r;
    assign data_pulse_o = data_pulse_s;
    assign eng_data_o   = {cap_reg_r, cap_wdata_r};
    assign eng_rw_o     = cap_rw_r;
    assign eng_start_o  = start_r;

endmodule

// File: tb/tb_sccb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sccb_arbiter
//   Directed and randomized bench for sccb_arbiter with a behavioural engine
//   model and a transaction-level expectation model (round-robin order,
//   attempt count, error/timeout flags, read data).
// -----------------------------------------------------------------------------
module tb_sccb_arbiter;

    localparam int IN_FREQ   = 1_600_000;
    localparam int SCCB_FREQ = 100_000;
    localparam int MAX_RETRY = 3;
    localparam int TMO_P     = 64;
    localparam int WAIT_MAX  = 4000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req0_i = 1'b0, req1_i = 1'b0;
    logic        rw0_i = 1'b0, rw1_i = 1'b0;
    logic [7:0]  reg0_i = 8'd0, reg1_i = 8'd0, wdata0_i = 8'd0, wdata1_i = 8'd0;
    logic        ack0_o, ack1_o, err0_o, err1_o, tmo_o;
    logic [7:0]  rdata_o;
    logic [1:0]  gnt_o;
    logic        sccb_clk_o, data_pulse_o, eng_rw_o, eng_start_o;
    logic [15:0] eng_data_o;
    logic        eng_done_i, eng_ack_error_i;
    logic [7:0]  eng_data_i;

    always #5 clk_i = ~clk_i;

    sccb_arbiter #(
        .IN_FREQ(IN_FREQ), .SCCB_FREQ(SCCB_FREQ),
        .MAX_RETRY(MAX_RETRY), .TIMEOUT_PULSES(TMO_P)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .req1_i(req1_i), .rw0_i(rw0_i), .rw1_i(rw1_i),
        .reg0_i(reg0_i), .reg1_i(reg1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .ack0_o(ack0_o), .ack1_o(ack1_o), .err0_o(err0_o), .err1_o(err1_o),
        .tmo_o(tmo_o), .rdata_o(rdata_o), .gnt_o(gnt_o),
        .sccb_clk_o(sccb_clk_o), .data_pulse_o(data_pulse_o),
        .eng_data_o(eng_data_o), .eng_rw_o(eng_rw_o), .eng_start_o(eng_start_o),
        .eng_done_i(eng_done_i), .eng_ack_error_i(eng_ack_error_i),
        .eng_data_i(eng_data_i)
    );

    // per-port scenario for the current round
    logic        rw_c[2];
    logic [7:0]  rg_c[2], wd_c[2], rd_c[2];
    int          nerr_c[2];
    logic        hang_c[2];
    int          lat_c = 2;

    // transaction-level expectation model
    logic        last_m = 1'b1;
    logic [7:0]  rdata_m = 8'd0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // engine model state
    logic        armed_m, busy_m, port_m, cur_err_m;
    int          left_m, att_m;
    logic [15:0] data_seen[2];
    logic        rw_seen[2];

    // Behavioural SCCBCtrl: starts on a start seen after a low start, fails
    // ACK on the first nerr_c attempts of a grant, never finishes when hung
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            eng_done_i      <= 1'b1;
            eng_ack_error_i <= 1'b0;
            eng_data_i      <= 8'd0;
            armed_m         <= 1'b1;
            busy_m          <= 1'b0;
            port_m          <= 1'b0;
            cur_err_m       <= 1'b0;
            left_m          <= 0;
            att_m           <= 0;
        end else begin
            if (gnt_o == 2'b00) att_m <= 0;
            if (data_pulse_o) begin
                if (!eng_start_o) armed_m <= 1'b1;
                if (busy_m) begin
                    if (left_m <= 1) begin
                        if (!hang_c[port_m]) begin
                            busy_m          <= 1'b0;
                            eng_done_i      <= 1'b1;
                            eng_ack_error_i <= cur_err_m;
                            eng_data_i      <= rd_c[port_m];
                        end
                    end else begin
                        left_m <= left_m - 1;
                    end
                end else if (eng_start_o && armed_m) begin
                    armed_m         <= 1'b0;
                    busy_m          <= 1'b1;
                    eng_done_i      <= 1'b0;
                    eng_ack_error_i <= 1'b0;
                    left_m          <= lat_c;
                    port_m          <= gnt_o[1];
                    cur_err_m       <= (att_m < nerr_c[gnt_o[1]]);
                    att_m           <= att_m + 1;
                    data_seen[gnt_o[1]] <= eng_data_o;
                    rw_seen[gnt_o[1]]   <= eng_rw_o;
                end
            end
        end
    end

    // monitor: ack pulses, start rising edges, low-start pulses before each rise
    int   n_ack0 = 0, n_ack1 = 0, n_rise = 0, bad_gap = 0, low_pulses = 0;
    logic start_prev = 1'b0;
    always @(negedge clk_i) begin
        if (ack0_o) n_ack0 <= n_ack0 + 1;
        if (ack1_o) n_ack1 <= n_ack1 + 1;
        if (eng_start_o && !start_prev) begin
            n_rise     <= n_rise + 1;
            low_pulses <= 0;
            if (low_pulses == 0) bad_gap <= bad_gap + 1;
        end else if (data_pulse_o && !eng_start_o) begin
            low_pulses <= low_pulses + 1;
        end
        start_prev <= eng_start_o;
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req0_i = 1'b0;
        req1_i = 1'b0;
        rst_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i   = 1'b1;
        last_m  = 1'b1;
        rdata_m = 8'd0;
        @(negedge clk_i);
    endtask

    task automatic cfg(input int p, input logic rw, input logic [7:0] rg,
                       input logic [7:0] wd, input logic [7:0] rd, input int ne,
                       input logic hg);
        rw_c[p] = rw; rg_c[p] = rg; wd_c[p] = wd; rd_c[p] = rd;
        nerr_c[p] = ne; hang_c[p] = hg;
    endtask

    // One round: raise the enabled requests together, serve them all
    task automatic run_round(input logic en0, input logic en1);
        int       base0, base1, base_r, w, exp_att;
        logic     p, exp_p, e;
        logic [1:0] pend;
        base0 = n_ack0; base1 = n_ack1; base_r = n_rise;
        @(negedge clk_i);
        rw0_i = rw_c[0]; reg0_i = rg_c[0]; wdata0_i = wd_c[0];
        rw1_i = rw_c[1]; reg1_i = rg_c[1]; wdata1_i = wd_c[1];
        req0_i = en0; req1_i = en1;
        pend  = {en1, en0};
        exp_p = (en0 && en1) ? ~last_m : en1;
        @(negedge clk_i);
        chk("gnt_latency", gnt_o, exp_p ? 2'b10 : 2'b01);
        while (pend != 2'b00) begin
            w = 0;
            while (!(ack0_o || ack1_o) && w < WAIT_MAX) begin
                @(negedge clk_i);
                w++;
            end
            if (w >= WAIT_MAX) begin
                n_cmp++;
                n_bad++;
                $error("FAIL ack_wait: no ack within %0d clks, expected port %0d", WAIT_MAX, exp_p);
                do_reset();
                return;
            end
            p = ack1_o;
            chk("ack_port", p, exp_p);
            e = hang_c[p] || (nerr_c[p] > MAX_RETRY);
            exp_att = hang_c[p] ? 1 : ((nerr_c[p] > MAX_RETRY) ? MAX_RETRY + 1 : nerr_c[p] + 1);
            chk("err", p ? err1_o : err0_o, e);
            chk("tmo", tmo_o, hang_c[p]);
            if (rw_c[p] && !e) rdata_m = rd_c[p];
            chk("rdata", rdata_o, rdata_m);
            chk("attempts", n_rise - base_r, exp_att);
            base_r = n_rise;
            chk("eng_data", data_seen[p], {rg_c[p], wd_c[p]});
            chk("eng_rw", rw_seen[p], rw_c[p]);
            if (p) req1_i = 1'b0; else req0_i = 1'b0;
            pend[p] = 1'b0;
            last_m  = p;
            @(negedge clk_i);
            chk("gnt_idle", gnt_o, 2'b00);
            if (pend != 2'b00) begin
                exp_p = ~p;
                @(negedge clk_i);
                chk("regrant", gnt_o, exp_p ? 2'b10 : 2'b01);
            end
        end
        repeat (3) @(negedge clk_i);
        chk("ack0_count", n_ack0 - base0, en0);
        chk("ack1_count", n_ack1 - base1, en1);
        chk("start_gap", bad_gap, 0);
    endtask

    initial begin
        int w, b0, b1, mode;
        cfg(0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        cfg(1, 1'b0, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        // reset state
        #1 rst_i = 1'b0;
        #1;
        chk("reset_outputs", {ack0_o, ack1_o, err0_o, err1_o, tmo_o, rdata_o, gnt_o,
                              sccb_clk_o, data_pulse_o, eng_data_o, eng_rw_o, eng_start_o}, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        // single write on port 1
        cfg(1, 1'b0, 8'h12, 8'h80, 8'h00, 0, 1'b0);
        lat_c = 3;
        run_round(1'b0, 1'b1);

        // contention twice: port 0 wins both times
        cfg(0, 1'b0, 8'h21, 8'h05, 8'h00, 0, 1'b0);
        cfg(1, 1'b0, 8'h33, 8'h44, 8'h00, 0, 1'b0);
        run_round(1'b1, 1'b1);
        run_round(1'b1, 1'b1);

        // read on port 0
        cfg(0, 1'b1, 8'h0A, 8'h00, 8'h76, 0, 1'b0);
        run_round(1'b1, 1'b0);

        // two ACK errors then success
        cfg(0, 1'b0, 8'h40, 8'h11, 8'h00, 2, 1'b0);
        run_round(1'b1, 1'b0);

        // persistent ACK error on a read: rdata must be kept
        cfg(1, 1'b1, 8'h50, 8'h00, 8'hEE, 9, 1'b0);
        run_round(1'b0, 1'b1);

        // randomized rounds
        for (int r = 0; r < 12; r++) begin
            for (int q = 0; q < 2; q++) begin
                cfg(q, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    8'($urandom), int'($urandom_range(0, 5)), 1'b0);
            end
            lat_c = int'($urandom_range(1, 4));
            mode  = int'($urandom_range(0, 2));
            run_round(mode != 1, mode != 0);
        end

        // engine never returns done: watchdog abort
        cfg(1, 1'b1, 8'h66, 8'h00, 8'h99, 0, 1'b1);
        run_round(1'b0, 1'b1);
        hang_c[1] = 1'b0;
        do_reset();

        // reset asserted while BUSY
        cfg(0, 1'b0, 8'h77, 8'h01, 8'h00, 0, 1'b1);
        @(negedge clk_i);
        rw0_i = 1'b0; reg0_i = 8'h77; wdata0_i = 8'h01;
        req0_i = 1'b1;
        w = 0;
        while (!eng_start_o && w < WAIT_MAX) begin
            @(negedge clk_i);
            w++;
        end
        chk("busy_reached", eng_start_o, 1'b1);
        repeat (60) @(negedge clk_i);
        b0 = n_ack0; b1 = n_ack1;
        #2 rst_i = 1'b0;
        req0_i = 1'b0;
        #1;
        chk("rst_mid_busy", {ack0_o, ack1_o, err0_o, err1_o, tmo_o, rdata_o, gnt_o,
                             sccb_clk_o, data_pulse_o, eng_data_o, eng_rw_o, eng_start_o}, 0);
        hang_c[0] = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        last_m = 1'b1;
        rdata_m = 8'd0;
        repeat (400) @(negedge clk_i);
        chk("no_ack_after_rst", (n_ack0 - b0) + (n_ack1 - b1), 0);
        chk("gnt_after_rst", gnt_o, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
